// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the single-issue datapath.
// Sequences fetch, decode, execute, data-memory access and writeback, gates
// decoder enables into one-cycle strobes, times out stalled memory handshakes
// and counts retired instructions.
// Optional build macro: SEQ_ILLEGAL_TRAP_EN (illegal opcode halts with illegal_err).
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                ir_load,
    input  logic [6:0]          opcode,
    input  logic                dec_rf_wr_en,
    input  logic                dec_dmem_wr_en,
    input  logic                branch_cond,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                rf_wr_en,
    output logic                pc_wr_en,
    output logic                pc_target_sel,
    output logic                busy,
    output logic                halted,
    output logic                timeout_err,
    output logic                illegal_err,
    output logic [RETIRE_W-1:0] retired,
    output logic [2:0]          state
);

    // Wait counter only needs to reach MEM_TIMEOUT; keep at least one bit.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W:0] WAIT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_U      = 7'b0110111;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    // C_NOP covers any opcode outside the recognised classes.
    typedef enum logic [2:0] {
        C_R, C_I, C_J, C_U, C_B, C_S, C_LOAD, C_NOP
    } cls_e;

    state_e                state_q, state_d;
    cls_e                  cls_q, cls_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [WAIT_W:0]       wait_inc;
    logic                  wait_expired;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic                  to_q, to_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic                  ill_q, ill_d;
`endif

    function automatic cls_e classify(input logic [6:0] op);
        cls_e c;
        case (op)
            OP_R:    c = C_R;
            OP_I:    c = C_I;
            OP_J:    c = C_J;
            OP_U:    c = C_U;
            OP_B:    c = C_B;
            OP_S:    c = C_S;
            OP_LOAD: c = C_LOAD;
            default: c = C_NOP;
        endcase
        return c;
    endfunction

    // Next-state, counters and all outputs from the registered state.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        to_d      = to_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
        ill_d     = ill_q;
`endif
        wait_inc     = {1'b0, wait_q} + 1'b1;
        // Ready on the limit cycle is checked first by the callers, so it wins.
        wait_expired = (MEM_TIMEOUT > 0) && (wait_inc == WAIT_LIM);

        imem_req      = (state_q == S_FETCH);
        dmem_req      = (state_q == S_MEM);
        dmem_we       = (state_q == S_MEM) && (cls_q == C_S) && dec_dmem_wr_en;
        busy          = (state_q != S_IDLE) && (state_q != S_HALT);
        halted        = (state_q == S_HALT);
        state         = state_q;
        ir_load       = 1'b0;
        rf_wr_en      = 1'b0;
        pc_wr_en      = 1'b0;
        pc_target_sel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    to_d    = 1'b1;
                end else begin
                    wait_d = wait_inc[WAIT_W-1:0];
                end
            end
            S_DECODE: begin
                cls_d = classify(opcode);
                if (opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
`ifdef SEQ_ILLEGAL_TRAP_EN
                end else if (classify(opcode) == C_NOP) begin
                    state_d = S_HALT;
                    ill_d   = 1'b1;
`endif
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if ((cls_q == C_LOAD) || (cls_q == C_S)) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                    wait_d  = '0;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    to_d    = 1'b1;
                end else begin
                    wait_d = wait_inc[WAIT_W-1:0];
                end
            end
            S_WRITEBACK: begin
                rf_wr_en      = dec_rf_wr_en &&
                                ((cls_q == C_R) || (cls_q == C_I) || (cls_q == C_J) ||
                                 (cls_q == C_U) || (cls_q == C_LOAD));
                pc_wr_en      = 1'b1;
                pc_target_sel = (cls_q == C_J) || ((cls_q == C_B) && branch_cond);
                retired_d     = retired_q + 1'b1;
                state_d       = S_FETCH;
                wait_d        = '0;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset is asynchronous so a stuck handshake can always be aborted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NOP;
            wait_q    <= '0;
            retired_q <= '0;
            to_q      <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            ill_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            to_q      <= to_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
            ill_q     <= ill_d;
`endif
        end
    end

    assign retired     = retired_q;
    assign timeout_err = to_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign illegal_err = ill_q;
`else
    assign illegal_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: table-driven instruction vectors,
// hand-written halt/reset sequences and randomized instructions checked
// against an instruction-level timing model.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    localparam int MT = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_U      = 7'b0110111;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_ILL    = 7'b1111111;

    logic        clock = 1'b0;
    logic        reset_n, start, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        dec_rf_wr_en, dec_dmem_wr_en, branch_cond;
    logic        imem_req, ir_load, dmem_req, dmem_we, rf_wr_en, pc_wr_en, pc_target_sel;
    logic        busy, halted, timeout_err, illegal_err;
    logic [31:0] retired;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int model_retired = 0;

    always #5 clock = ~clock;

    multicycle_sequencer #(.MEM_TIMEOUT(MT), .RETIRE_W(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .imem_req(imem_req), .imem_ready(imem_ready), .ir_load(ir_load),
        .opcode(opcode), .dec_rf_wr_en(dec_rf_wr_en), .dec_dmem_wr_en(dec_dmem_wr_en),
        .branch_cond(branch_cond), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .rf_wr_en(rf_wr_en), .pc_wr_en(pc_wr_en),
        .pc_target_sel(pc_target_sel), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .illegal_err(illegal_err),
        .retired(retired), .state(state)
    );

    typedef struct {
        logic [6:0] op;
        logic       rfwe;
        logic       dwe;
        logic       br;
        int         idly;
        int         ddly;
        int         exp_cycles;
        int         exp_dreq;
        int         exp_dwe;
        int         exp_rfw;
        int         exp_pcw;
        int         exp_tsel;
        logic       exp_halt;
        logic       exp_to;
        logic       exp_ill;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic rfwe, input logic dwe,
                                input logic br, input int idly, input int ddly,
                                input int cyc, input int dreq, input int dwec, input int rfw,
                                input int pcw, input int tsel, input logic h,
                                input logic to, input logic ill);
        vec_t v;
        v.op = op; v.rfwe = rfwe; v.dwe = dwe; v.br = br; v.idly = idly; v.ddly = ddly;
        v.exp_cycles = cyc; v.exp_dreq = dreq; v.exp_dwe = dwec; v.exp_rfw = rfw;
        v.exp_pcw = pcw; v.exp_tsel = tsel; v.exp_halt = h; v.exp_to = to; v.exp_ill = ill;
        return v;
    endfunction

    // Instruction-level model: cycles = fetch(+waits) + decode + execute + mem(+waits) + writeback.
    function automatic vec_t model(input logic [6:0] op, input logic rfwe, input logic dwe,
                                   input logic br, input int idly, input int ddly);
        bit is_mem, writes;
        int mem_cycles;
        is_mem     = (op == OP_LOAD) || (op == OP_S);
        writes     = (op == OP_R) || (op == OP_I) || (op == OP_J) || (op == OP_U) || (op == OP_LOAD);
        mem_cycles = is_mem ? ddly + 1 : 0;
        return mk(op, rfwe, dwe, br, idly, ddly,
                  (idly + 1) + 1 + 1 + mem_cycles + 1,
                  mem_cycles,
                  ((op == OP_S) && dwe) ? mem_cycles : 0,
                  (rfwe && writes) ? 1 : 0,
                  1,
                  ((op == OP_J) || ((op == OP_B) && br)) ? 1 : 0,
                  1'b0, 1'b0, 1'b0);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_retired = 0;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Drives one instruction from its first FETCH cycle until writeback or halt.
    task automatic run_instr(input vec_t v, input string tag);
        int cyc = 0, ireq = 0, irl = 0, dreq = 0, dwec = 0, rfw = 0, pcw = 0, tsel = 0;
        int ifc = 0, mfc = 0;
        bit done = 0;
        logic [31:0] ret_first = '0;
        int exp_ireq, exp_irl;
        opcode = v.op; dec_rf_wr_en = v.rfwe; dec_dmem_wr_en = v.dwe; branch_cond = v.br;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clock);
            imem_ready = (state == 3'd1) && (ifc == v.idly);
            if (state == 3'd1) ifc++;
            dmem_ready = (state == 3'd4) && (mfc == v.ddly);
            if (state == 3'd4) mfc++;
            #1;
            if (k == 0) ret_first = retired;
            if (state == 3'd6) begin
                done = 1;
            end else begin
                if (busy) cyc++;
                ireq += int'(imem_req);
                irl  += int'(ir_load);
                dreq += int'(dmem_req);
                dwec += int'(dmem_we);
                rfw  += int'(rf_wr_en);
                pcw  += int'(pc_wr_en);
                tsel += int'(pc_target_sel);
                if (pc_wr_en) done = 1;
            end
        end
        exp_ireq = (v.idly >= MT) ? MT : v.idly + 1;
        exp_irl  = (v.idly >= MT) ? 0 : 1;
        chk({tag, ".completed"}, done, 1);
        chk({tag, ".retired_at_fetch"}, ret_first, model_retired);
        chk({tag, ".cycles"}, cyc, v.exp_cycles);
        chk({tag, ".imem_req_cycles"}, ireq, exp_ireq);
        chk({tag, ".ir_load_count"}, irl, exp_irl);
        chk({tag, ".dmem_req_cycles"}, dreq, v.exp_dreq);
        chk({tag, ".dmem_we_cycles"}, dwec, v.exp_dwe);
        chk({tag, ".rf_wr_en_count"}, rfw, v.exp_rfw);
        chk({tag, ".pc_wr_en_count"}, pcw, v.exp_pcw);
        chk({tag, ".pc_target_sel"}, tsel, v.exp_tsel);
        chk({tag, ".halted"}, halted, v.exp_halt);
        chk({tag, ".timeout_err"}, timeout_err, v.exp_to);
        chk({tag, ".illegal_err"}, illegal_err, v.exp_ill);
        if (!v.exp_halt) model_retired++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops[$];
        vec_t v;
        bit hit;

        // Reset state, with inputs that would otherwise provoke strobes.
        reset_n = 1'b0; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        opcode = OP_R; dec_rf_wr_en = 1'b1; dec_dmem_wr_en = 1'b1; branch_cond = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("reset.state", state, 0);
        chk("reset.busy", busy, 0);
        chk("reset.halted", halted, 0);
        chk("reset.imem_req", imem_req, 0);
        chk("reset.ir_load", ir_load, 0);
        chk("reset.pc_wr_en", pc_wr_en, 0);
        chk("reset.retired", retired, 0);
        chk("reset.timeout_err", timeout_err, 0);
        chk("reset.illegal_err", illegal_err, 0);
        do_reset();
        repeat (2) @(negedge clock);
        #1 chk("idle_without_start", state, 0);

        // Hand-derived vectors.
        tbl.push_back(mk(OP_R,    1, 0, 0, 0,  0,  4,  0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LOAD, 1, 0, 0, 0,  3,  8,  4, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_S,    0, 1, 0, 0,  0,  5,  1, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_B,    0, 0, 1, 0,  0,  4,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(OP_B,    0, 0, 0, 0,  0,  4,  0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_J,    1, 0, 0, 0,  0,  4,  0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(OP_U,    1, 0, 0, 2,  0,  6,  0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_I,    1, 0, 0, 0,  0,  4,  0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_B,    1, 0, 1, 1,  0,  5,  0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(OP_S,    1, 1, 0, 0,  2,  7,  3, 3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_R,    1, 0, 0, 15, 0,  19, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_LOAD, 0, 0, 0, 0,  15, 20, 16, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(OP_J,    0, 0, 1, 0,  0,  4,  0, 0, 0, 1, 1, 0, 0, 0));
`ifndef SEQ_ILLEGAL_TRAP_EN
        tbl.push_back(mk(OP_ILL,  1, 1, 1, 0,  0,  4,  0, 0, 0, 1, 0, 0, 0, 0));
`endif
        do_start();
        for (int i = 0; i < tbl.size(); i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        // Randomized instruction stream against the model.
        ops = '{OP_R, OP_I, OP_J, OP_U, OP_B, OP_S, OP_LOAD};
`ifndef SEQ_ILLEGAL_TRAP_EN
        ops.push_back(OP_ILL);
        ops.push_back(7'b0000000);
`endif
        for (int i = 0; i < 40; i++) begin
            v = model(ops[$urandom_range(ops.size() - 1)], 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(3), $urandom_range(3));
            run_instr(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a stalled LOAD.
        opcode = OP_LOAD; dec_rf_wr_en = 1'b1; dec_dmem_wr_en = 1'b0;
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clock);
            imem_ready = (state == 3'd1);
            dmem_ready = 1'b0;
            #1;
            if (state == 3'd4) hit = 1;
        end
        chk("midmem.reached_mem", hit, 1);
        chk("midmem.dmem_req_before", dmem_req, 1);
        chk("midmem.retired_before", retired, model_retired);
        #2 reset_n = 1'b0;
        #1;
        chk("midmem.state", state, 0);
        chk("midmem.dmem_req", dmem_req, 0);
        chk("midmem.retired", retired, 0);
        chk("midmem.busy", busy, 0);
        do_reset();

        // SYSTEM opcode halts; HALT absorbs start and ready.
        do_start();
        run_instr(model(OP_R, 1, 0, 0, 0, 0), "sys_pre");
        run_instr(mk(OP_SYSTEM, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0), "system");
        start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("halt.state", state, 6);
        chk("halt.imem_req", imem_req, 0);
        chk("halt.pc_wr_en", pc_wr_en, 0);
        chk("halt.busy", busy, 0);
        chk("halt.retired", retired, 1);
        do_reset();

        // Fetch timeout: ready never arrives.
        do_start();
        run_instr(mk(OP_R, 1, 0, 0, 16, 0, 16, 0, 0, 0, 0, 0, 1, 1, 0), "fetch_timeout");
        @(negedge clock);
        #1;
        chk("fetch_timeout.imem_req_after", imem_req, 0);
        chk("fetch_timeout.sticky", timeout_err, 1);
        do_reset();
        #1 chk("fetch_timeout.cleared_by_reset", timeout_err, 0);

        // Data memory timeout on a LOAD.
        do_start();
        run_instr(mk(OP_LOAD, 1, 0, 0, 0, 20, 19, 16, 0, 0, 0, 0, 1, 1, 0), "mem_timeout");
        do_reset();

`ifdef SEQ_ILLEGAL_TRAP_EN
        // Illegal opcode traps to HALT without retiring.
        do_start();
        run_instr(model(OP_R, 1, 0, 0, 0, 0), "trap_pre");
        run_instr(mk(OP_ILL, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1), "illegal_trap");
        @(negedge clock);
        #1 chk("illegal_trap.retired", retired, 1);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the single-issue datapath: instruction fetch, decode, execute, data-memory access, register writeback and PC update.
- Consumes the instruction decoder's opcode and write-enable outputs and gates them into one-cycle strobes.
- Handles valid/ready handshakes toward instruction and data memory, with a wait timeout.
- Keeps a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before error halt; 0 disables timeout.
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin execution from IDLE
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction word valid this cycle
- ir_load  out  1  latch instruction register
- opcode  in  7  instruction[6:0] from decoder OPERATION
- dec_rf_wr_en  in  1  decoder RF_WR_EN
- dec_dmem_wr_en  in  1  decoder DATA_MEMORY_WR_EN
- branch_cond  in  1  ALU branch comparison result
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- dmem_ready  in  1  data access complete
- rf_wr_en  out  1  register file write strobe
- pc_wr_en  out  1  PC update strobe
- pc_target_sel  out  1  0 = PC+4, 1 = immediate target
- busy  out  1  state is not IDLE or HALT
- halted  out  1  in HALT
- timeout_err  out  1  sticky, memory wait exceeded
- illegal_err  out  1  sticky, illegal opcode (0 unless macro defined)
- retired  out  RETIRE_W  instructions retired
- state  out  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- Reset (async, any state, mid-handshake included): state=IDLE. All outputs 0, retired=0, wait counter=0, error flags cleared.
- Moore outputs, decoded from registered state: imem_req=(FETCH), dmem_req=(MEM), busy, halted, state.
  - dmem_we=(MEM & store). Store class is latched in DECODE.
- Mealy strobes, single cycle:
  - ir_load = FETCH & imem_ready.
  - rf_wr_en, pc_wr_en, pc_target_sel asserted only in WRITEBACK.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH: imem_req held high until imem_ready sampled high -> DECODE.
- DECODE (1 cycle): latch instruction class from opcode.
  - 0110011=R, 0010011=I, 1101111=J, 0110111=U, 1100011=B, 0100011=S, 0000011=LOAD.
  - 1110011 (SYSTEM) -> HALT.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle): LOAD or S -> MEM; else -> WRITEBACK.
- MEM: dmem_req held until dmem_ready -> WRITEBACK. dmem_we = dec_dmem_wr_en for S; 0 for LOAD.
- WRITEBACK (1 cycle):
  - rf_wr_en = dec_rf_wr_en & class in {R, I, J, U, LOAD}.
  - pc_wr_en = 1.
  - pc_target_sel = J | (B & branch_cond).
  - retired += 1, wrapping modulo 2^RETIRE_W.
  - Next state -> FETCH.
- Latency, zero-wait memory: 4 cycles per non-memory instruction, 5 per LOAD/S.
- Wait counter:
  - Clears on entry to FETCH/MEM and on any ready.
  - Increments each FETCH/MEM cycle with ready low.
  - If MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT with ready still low: -> HALT, timeout_err=1.
  - Ready arriving on the same cycle the counter reaches the limit wins; no timeout.
- HALT: absorbing. All strobes 0, halted=1, error flags hold. Exit only by reset.
- Exactly one PC update and at most one RF write per retired instruction.

Optional Feature:
- Macro SEQ_ILLEGAL_TRAP_EN.
- Defined: an opcode outside the eight listed classes moves DECODE -> HALT with illegal_err=1. No PC update, not retired.
- Undefined: such an opcode is a NOP. It passes EXECUTE -> WRITEBACK with rf_wr_en=0, pc_wr_en=1, pc_target_sel=0, and is counted in retired. illegal_err is tied 0.

Test Plan:
- Reset mid-MEM with dmem_req high, reset_n pulsed low -> state=0, dmem_req=0, retired=0 immediately, without waiting for a clock edge.
- start, imem_ready always 1, opcode=0110011, dec_rf_wr_en=1 -> ir_load at cycle 1, rf_wr_en and pc_wr_en on cycle 4, pc_target_sel=0, retired=1.
- Load with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, rf_wr_en in WRITEBACK, 8 cycles total.
- Store, then branch with branch_cond=1, then branch with branch_cond=0:
  - Store -> dmem_we=1, rf_wr_en=0.
  - Taken branch -> pc_target_sel=1.
  - Not-taken branch -> pc_target_sel=0.
  - retired=3 at end.
- MEM_TIMEOUT=16, imem_ready held 0 -> HALT after 16 FETCH cycles, timeout_err=1, imem_req drops. Repeat with ready on the 16th cycle -> no error.
- opcode=1111111:
  - With macro defined -> HALT, illegal_err=1, retired unchanged.
  - With macro undefined -> NOP, pc_wr_en=1, retired+1.
